product_bcd_display: RTL and testbench

Downstream consumer of the 4x4 multiplier (tt_um_mult4x4). On each rising edge of the multiplier's done_flag it captures the 8-bit product and converts it to 3-digit BCD with an iterative shift-add-3 (double-dabble) engine. It then drives a time-multiplexed 3-digit 7-segment display from the last converted value. It sits between product4x4_out/done_flag and the board display pins.

---
 rtl/product_bcd_display.sv | 132 +++++++++++++
 tb/tb_product_bcd_display.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_display.sv
// Captures the 4x4 multiplier product, converts it to 3-digit BCD with a
// double-dabble engine and scans it onto a multiplexed 7-segment display.
module product_bcd_display #(
   parameter int SCAN_DIV = 1024,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        done_flag,
   input  logic [7:0]  product_in,
   output logic        busy,
   output logic        bcd_valid,
   output logic [11:0] bcd_out,
   output logic [6:0]  seg_out,
   output logic [2:0]  digit_sel
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t        state;
   logic          done_q;
   logic [7:0]    shift;
   logic [11:0]   bcd_work;
   logic [2:0]    bit_cnt;
   logic          rise;
   logic [11:0]   adj;
   logic [19:0]   shifted;
   logic [CW-1:0] scan_cnt;
   logic [3:0]    digit;
   logic          blank;

   function automatic logic [6:0] seg_map(input logic [3:0] d);
      case (d)
         4'd0:    seg_map = 7'h3F;
         4'd1:    seg_map = 7'h06;
         4'd2:    seg_map = 7'h5B;
         4'd3:    seg_map = 7'h4F;
         4'd4:    seg_map = 7'h66;
         4'd5:    seg_map = 7'h6D;
         4'd6:    seg_map = 7'h7D;
         4'd7:    seg_map = 7'h07;
         4'd8:    seg_map = 7'h7F;
         4'd9:    seg_map = 7'h6F;
         default: seg_map = 7'h00;
      endcase
   endfunction

   // NOTE: combinational blocks assign defaults first so no path infers a latch.
   always_comb begin
      rise = done_flag & ~done_q;
      adj  = bcd_work;
      for (int i = 0; i < 3; i++) begin
         if (bcd_work[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
      shifted = {adj, shift} << 1;
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state     <= IDLE;
         busy      <= 1'b0;
         bcd_valid <= 1'b0;
         bcd_out   <= 12'h000;
         done_q    <= 1'b0;
         shift     <= 8'h00;
         bcd_work  <= 12'h000;
         bit_cnt   <= 3'd0;
      end else begin
         done_q    <= done_flag;
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  shift    <= product_in;
                  bcd_work <= 12'h000;
                  bit_cnt  <= 3'd0;
                  busy     <= 1'b1;
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_work <= shifted[19:8];
               shift    <= shifted[7:0];
               bit_cnt  <= bit_cnt + 3'd1;
               // Eighth shift: publish the result straight from the shifter output.
               if (bit_cnt == 3'd7) begin
                  bcd_out   <= shifted[19:8];
                  bcd_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Display scan runs freely, unaffected by the conversion FSM.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         scan_cnt  <= '0;
         digit_sel <= 3'b001;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         digit_sel <= {digit_sel[1:0], digit_sel[2]};
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      digit = bcd_out[3:0];
      blank = 1'b0;
      case (digit_sel)
         3'b010: begin
            digit = bcd_out[7:4];
            blank = BLANK_LZ && (bcd_out[11:4] == 8'h00);
         end
         3'b100: begin
            digit = bcd_out[11:8];
            blank = BLANK_LZ && (bcd_out[11:8] == 4'h0);
         end
         default: ;
      endcase
      seg_out = blank ? 7'h00 : seg_map(digit);
   end

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed-vector bench for product_bcd_display: conversion, latency, busy
// collisions, mid-conversion reset, scan rotation and leading-zero blanking.
module tb_product_bcd_display;

   logic        clk;
   logic        reset_a;
   logic        done_flag;
   logic [7:0]  product_in;
   logic        busy, bcd_valid;
   logic [11:0] bcd_out;
   logic [6:0]  seg_out;
   logic [2:0]  digit_sel;
   logic        busy_nb, bcd_valid_nb;
   logic [11:0] bcd_out_nb;
   logic [6:0]  seg_out_nb;
   logic [2:0]  digit_sel_nb;

   int n_cmp = 0;
   int n_err = 0;

   product_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset_a(reset_a), .done_flag(done_flag), .product_in(product_in),
      .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out),
      .seg_out(seg_out), .digit_sel(digit_sel)
   );

   product_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .reset_a(reset_a), .done_flag(done_flag), .product_in(product_in),
      .busy(busy_nb), .bcd_valid(bcd_valid_nb), .bcd_out(bcd_out_nb),
      .seg_out(seg_out_nb), .digit_sel(digit_sel_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits up to max_cyc negedges for bcd_valid; lat is the negedge index it appeared on.
   task automatic wait_valid(input string tag, input int max_cyc, output int lat);
      logic found;
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= max_cyc && !found; i++) begin
         @(negedge clk);
         if (bcd_valid) begin
            found = 1'b1;
            lat   = i;
         end
      end
      check({tag, "_seen"}, 16'(found), 16'd1);
   endtask

   task automatic convert(input string tag, input logic [7:0] p, input logic [11:0] exp);
      int lat;
      @(negedge clk);
      done_flag = 1'b0;
      @(negedge clk);
      product_in = p;
      done_flag  = 1'b1;
      wait_valid(tag, 20, lat);
      check({tag, "_lat"}, 16'(lat), 16'd9);
      check(tag, 16'(bcd_out), 16'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int lat;
      logic [2:0] prev_sel;
      logic synced;
      logic [2:0] exp_sel [3];
      logic [6:0] exp_seg [3];
      logic [6:0] exp_nb  [3];

      reset_a    = 1'b1;
      done_flag  = 1'b0;
      product_in = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy",   16'(busy),       16'd0);
      check("rst_valid",  16'(bcd_valid),  16'd0);
      check("rst_bcd",    16'(bcd_out),    16'h000);
      check("rst_sel",    16'(digit_sel),  16'b001);
      check("rst_seg",    16'(seg_out),    16'h3F);
      check("rst_seg_nb", 16'(seg_out_nb), 16'h3F);
      reset_a = 1'b0;

      // Single conversion 225 with busy window and no retrigger on held level
      @(negedge clk);
      product_in = 8'hE1;
      done_flag  = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy && !bcd_valid) cnt++;
      end
      check("busy_cycles", 16'(cnt), 16'd8);
      @(negedge clk);
      check("e1_valid", 16'(bcd_valid), 16'd1);
      check("e1_busy",  16'(busy),      16'd0);
      check("e1_bcd",   16'(bcd_out),   16'h225);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bcd_valid) cnt++;
      end
      check("held_no_retrig", 16'(cnt), 16'd0);
      check("e1_hold", 16'(bcd_out), 16'h225);

      // Boundaries
      convert("b00", 8'h00, 12'h000);
      convert("b09", 8'h09, 12'h009);
      convert("b0a", 8'h0A, 12'h010);
      convert("b63", 8'h63, 12'h099);
      convert("bff", 8'hFF, 12'h255);

      // Busy collision: rise during conversion is dropped; rise right after valid is taken
      @(negedge clk);
      done_flag = 1'b0;
      @(negedge clk);
      product_in = 8'h51;
      done_flag  = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      @(negedge clk);
      product_in = 8'h10;
      done_flag  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      done_flag = 1'b0;
      wait_valid("collide", 12, lat);
      check("collide_lat", 16'(lat), 16'd5);
      check("collide_bcd", 16'(bcd_out), 16'h081);
      product_in = 8'h10;
      done_flag  = 1'b1;
      wait_valid("after_valid", 20, lat);
      check("after_valid_lat", 16'(lat), 16'd9);
      check("after_valid_bcd", 16'(bcd_out), 16'h016);

      // Reset mid-conversion, restart with done_flag already high at release
      @(negedge clk);
      done_flag = 1'b0;
      @(negedge clk);
      product_in = 8'hC8;
      done_flag  = 1'b1;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 16'(busy), 16'd1);
      reset_a = 1'b1;
      #1;
      check("mid_rst_bcd",  16'(bcd_out), 16'h000);
      check("mid_rst_busy", 16'(busy),    16'd0);
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (bcd_valid) cnt++;
      end
      check("mid_rst_no_valid", 16'(cnt), 16'd0);
      reset_a = 1'b0;
      wait_valid("restart", 20, lat);
      check("restart_lat", 16'(lat), 16'd9);
      check("restart_bcd", 16'(bcd_out), 16'h200);

      // Scan rotation and leading-zero blanking on 042
      convert("b2a", 8'h2A, 12'h042);
      check("nb_bcd", 16'(bcd_out_nb), 16'h042);
      synced   = 1'b0;
      prev_sel = digit_sel;
      for (int i = 0; i < 20 && !synced; i++) begin
         @(negedge clk);
         if (prev_sel == 3'b100 && digit_sel == 3'b001) synced = 1'b1;
         prev_sel = digit_sel;
      end
      check("scan_sync", 16'(synced), 16'd1);
      exp_sel = '{3'b001, 3'b010, 3'b100};
      exp_seg = '{7'h5B, 7'h66, 7'h00};
      exp_nb  = '{7'h5B, 7'h66, 7'h3F};
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (d != 0 || c != 0) @(negedge clk);
            check($sformatf("scan_sel_d%0d_c%0d", d, c),    16'(digit_sel),    16'(exp_sel[d]));
            check($sformatf("scan_seg_d%0d_c%0d", d, c),    16'(seg_out),      16'(exp_seg[d]));
            check($sformatf("scan_selnb_d%0d_c%0d", d, c),  16'(digit_sel_nb), 16'(exp_sel[d]));
            check($sformatf("scan_segnb_d%0d_c%0d", d, c),  16'(seg_out_nb),   16'(exp_nb[d]));
         end
      end
      @(negedge clk);
      check("scan_wrap_sel", 16'(digit_sel), 16'b001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
